// File: rtl/audio_pkg.sv
// Shared audio types and frame geometry for the I2S output path.
// A frame word is {left, right}, MSB of left transmitted first.
package audio_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [31:0] frame_t;

    localparam int SLOTS_PER_FRAME   = 32;
    localparam int SLOTS_PER_CHANNEL = 16;
    localparam int SLOT_W            = $clog2(SLOTS_PER_FRAME);

    function automatic frame_t pack_frame(input sample_t left, input sample_t right);
        return {left, right};
    endfunction

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock generator: bclk toggles every CLK_DIV system clocks.
// bclkFall is high in the cycle whose closing edge drives bclk from 1 to 0.
module bclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic bclkFall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             terminal;

    assign terminal = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign bclkFall = terminal && bclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// I2S serialiser for the DAC: slot counter, frame shift register, one-pair
// holding register with valid/ready handshake and sticky underrun flag.
module i2s_dac_transmitter
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  sample_t leftSampleIn,
    input  sample_t rightSampleIn,
    input  logic    sampleValid,
    output logic    sampleReady,
    output logic    frameStart,
    output logic    underrun,
    input  logic    clearUnderrun,
    output logic    bclk,
    output logic    lrclk,
    output logic    dacData
);

    logic              bclk_fall;
    logic [SLOT_W-1:0] bit_cnt;
    logic [SLOT_W-1:0] bit_cnt_next;
    frame_t            shift_reg;
    frame_t            next_frame;
    sample_t           hold_l;
    sample_t           hold_r;
    logic              hold_full;
    logic              frame_load;
    logic              set_underrun;

    bclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_divider (
        .clk      (clk),
        .reset    (reset),
        .bclk     (bclk),
        .bclkFall (bclk_fall)
    );

    assign bit_cnt_next = bit_cnt + SLOT_W'(1);
    assign frame_load   = bclk_fall && (bit_cnt_next == '0);
    assign sampleReady  = !hold_full;
    assign set_underrun = frame_load && !hold_full && !sampleValid;

    // Held pair has priority; an empty holder lets a same-cycle pair bypass it.
    always_comb begin
        next_frame = '0;
        if (hold_full) begin
            next_frame = pack_frame(hold_l, hold_r);
        end else if (sampleValid) begin
            next_frame = pack_frame(leftSampleIn, rightSampleIn);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= SLOT_W'(SLOTS_PER_FRAME - 1);
            lrclk      <= 1'b1;
            dacData    <= 1'b0;
            shift_reg  <= '0;
            hold_l     <= '0;
            hold_r     <= '0;
            hold_full  <= 1'b0;
            frameStart <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frameStart <= frame_load;

            // dacData lags shift_reg by one slot, giving the I2S one-bit delay.
            if (bclk_fall) begin
                bit_cnt   <= bit_cnt_next;
                lrclk     <= (bit_cnt_next >= SLOT_W'(SLOTS_PER_CHANNEL));
                dacData   <= shift_reg[31];
                shift_reg <= frame_load ? next_frame : (shift_reg << 1);
            end

            if (frame_load) begin
                hold_full <= 1'b0;
            end else if (sampleValid && sampleReady) begin
                hold_l    <= leftSampleIn;
                hold_r    <= rightSampleIn;
                hold_full <= 1'b1;
            end

            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (clearUnderrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Bench for i2s_dac_transmitter: frame table, hand sequences and random traffic,
// all compared each cycle against a slot-arithmetic reference model.
module tb_i2s_dac_transmitter;
    import audio_pkg::*;

    localparam int C     = 4;
    localparam int FRAME = 64 * C;
    localparam int MODE_NONE   = 0;
    localparam int MODE_HOLD   = 1;
    localparam int MODE_BYPASS = 2;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    sample_t leftSampleIn = '0;
    sample_t rightSampleIn = '0;
    logic    sampleValid = 1'b0;
    logic    clearUnderrun = 1'b0;
    logic    sampleReady, frameStart, underrun, bclk, lrclk, dacData;

    i2s_dac_transmitter #(.CLK_DIV(C)) dut (
        .clk           (clk),
        .reset         (reset),
        .leftSampleIn  (leftSampleIn),
        .rightSampleIn (rightSampleIn),
        .sampleValid   (sampleValid),
        .sampleReady   (sampleReady),
        .frameStart    (frameStart),
        .underrun      (underrun),
        .clearUnderrun (clearUnderrun),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .dacData       (dacData)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: n counts clock edges since reset release.
    int          n = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_cur = '0;
    logic [31:0] m_prev = '0;
    logic        m_und = 1'b0;
    logic        m_fs = 1'b0;
    logic        m_acc = 1'b0;
    logic [31:0] rx_acc = '0;
    logic [31:0] rx_q[$];

    typedef struct {
        int          mode;
        sample_t     l;
        sample_t     r;
        int          clr;       // 0 none, 1 in load cycle, 2 early in frame
        logic [31:0] exp_word;
        logic        exp_und;
    } vec_t;
    vec_t tbl[7];

    function automatic int load_n(input int i);
        return 2 * C + FRAME * i;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bclk, lrclk, dacData, sampleReady, frameStart, underrun});
    endfunction

    function automatic logic [31:0] expected_outs();
        int k, s;
        logic b, lr, d;
        logic [4:0] idx;
        b = ((n / C) % 2) == 1;
        k = n / (2 * C);
        if (k == 0) begin
            lr = 1'b1;
            d  = 1'b0;
        end else begin
            s  = (k - 1) % 32;
            lr = (s >= 16);
            idx = 5'(32 - s);
            d  = (s == 0) ? m_prev[0] : m_cur[idx];
        end
        return 32'({b, lr, d, !m_full, m_fs, m_und});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        logic load, set;
        int k, s;
        logic [4:0] idx;
        @(posedge clk);
        if (reset) begin
            n = 0; m_full = 0; m_und = 0; m_cur = '0; m_prev = '0; m_fs = 0; m_acc = 0;
            rx_q.delete();
        end else begin
            n++;
            m_acc = 0;
            set = 0;
            load = (n >= 2 * C) && (((n - 2 * C) % FRAME) == 0);
            m_fs = load;
            if (load) begin
                m_prev = m_cur;
                if (m_full) begin
                    m_cur = m_hold; m_full = 0;
                end else if (sampleValid) begin
                    m_cur = {leftSampleIn, rightSampleIn}; m_acc = 1;
                end else begin
                    m_cur = '0; set = 1;
                end
            end else if (sampleValid && !m_full) begin
                m_hold = {leftSampleIn, rightSampleIn}; m_full = 1; m_acc = 1;
            end
            if (set) m_und = 1;
            else if (clearUnderrun) m_und = 0;
        end
        @(negedge clk);
        check("outputs", outs(), expected_outs());
        if (!reset && n >= 3 * C && (n % (2 * C)) == C) begin
            k = n / (2 * C);
            s = (k - 1) % 32;
            if (s != 0) begin
                idx = 5'(32 - s);
                rx_acc[idx] = dacData;
            end else if (k > 1) begin
                rx_acc[0] = dacData;
                rx_q.push_back(rx_acc);
            end
        end
    endtask

    task automatic wait_n(input int target);
        while (n < target) tick();
    endtask

    initial begin
        int L, fi, target, rate;
        sample_t cnt;

        tbl[0] = '{MODE_HOLD,   16'h8001, 16'h7FFE, 0, 32'h8001_7FFE, 1'b0};
        tbl[1] = '{MODE_BYPASS, 16'h1234, 16'hABCD, 0, 32'h1234_ABCD, 1'b0};
        tbl[2] = '{MODE_NONE,   16'h0000, 16'h0000, 0, 32'h0000_0000, 1'b1};
        tbl[3] = '{MODE_NONE,   16'h0000, 16'h0000, 1, 32'h0000_0000, 1'b1};
        tbl[4] = '{MODE_HOLD,   16'h5A5A, 16'hA5A5, 0, 32'h5A5A_A5A5, 1'b1};
        tbl[5] = '{MODE_BYPASS, 16'hFFFF, 16'h0000, 1, 32'hFFFF_0000, 1'b0};
        tbl[6] = '{MODE_HOLD,   16'h0001, 16'h8000, 2, 32'h0001_8000, 1'b0};

        repeat (3) tick();
        check("reset_state", outs(), 32'b010100);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            L = load_n(i);
            if (tbl[i].clr == 2) begin
                wait_n(L - 20);
                clearUnderrun = 1'b1; tick(); clearUnderrun = 1'b0;
            end
            if (tbl[i].mode == MODE_HOLD) begin
                wait_n(L - 10);
                leftSampleIn = tbl[i].l; rightSampleIn = tbl[i].r; sampleValid = 1'b1;
                tick();
                sampleValid = 1'b0;
            end
            wait_n(L - 1);
            if (tbl[i].mode == MODE_BYPASS) begin
                leftSampleIn = tbl[i].l; rightSampleIn = tbl[i].r; sampleValid = 1'b1;
            end
            if (tbl[i].clr == 1) clearUnderrun = 1'b1;
            tick();
            sampleValid = 1'b0; clearUnderrun = 1'b0;
            wait_n(L + 3);
            check($sformatf("underrun_row%0d", i), 32'(underrun), 32'(tbl[i].exp_und));
        end
        wait_n(load_n(7) + C);
        check("table_frames", 32'(rx_q.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < rx_q.size()) check($sformatf("frame_word%0d", i), rx_q[i], tbl[i].exp_word);

        // Backpressure: valid held high, data advances only on acceptance.
        cnt = 16'sh0100;
        leftSampleIn = cnt; rightSampleIn = ~cnt; sampleValid = 1'b1;
        while (n < load_n(13) + C) begin
            tick();
            if (m_acc) begin
                cnt = cnt + 16'sd1;
                leftSampleIn = cnt; rightSampleIn = ~cnt;
            end
        end
        sampleValid = 1'b0;
        check("bp_frames", 32'(rx_q.size()), 32'd13);
        for (int j = 0; j < 5; j++)
            if (8 + j < rx_q.size())
                check($sformatf("bp_word%0d", j), rx_q[8 + j],
                      {16'h0100 + 16'(j), ~(16'h0100 + 16'(j))});

        // Random traffic with a per-chunk offer rate.
        for (int f = 0; f < 8; f++) begin
            case ($urandom_range(0, 2))
                0: rate = 0;
                1: rate = 2;
                default: rate = 50;
            endcase
            repeat (FRAME) begin
                sampleValid   = ($urandom_range(0, 99) < rate);
                leftSampleIn  = sample_t'(16'($urandom));
                rightSampleIn = sample_t'(16'($urandom));
                clearUnderrun = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        sampleValid = 1'b0; clearUnderrun = 1'b0;

        // Mid-frame reset in slot 20 with a pair pending in the holder.
        fi = (n - 2 * C) / FRAME;
        target = load_n(fi + 1) + 40 * C + 2;
        wait_n(target - 3);
        leftSampleIn = 16'h7777; rightSampleIn = 16'h3333; sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        wait_n(target);
        reset = 1'b1;
        tick();
        check("midreset_outputs", outs(), 32'b010100);
        reset = 1'b0;
        while (n < 8) begin
            tick();
            if (n == 3) check("restart_bclk_n3", 32'(bclk), 32'd0);
            if (n == 4) check("restart_bclk_n4", 32'({bclk, lrclk}), 32'b11);
            if (n == 7) check("restart_n7", 32'({bclk, lrclk, frameStart}), 32'b110);
            if (n == 8) check("restart_n8", 32'({bclk, lrclk, frameStart, underrun}), 32'b0011);
        end
        wait_n(20);
        leftSampleIn = 16'hC3A5; rightSampleIn = 16'h0F0F; sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        wait_n(load_n(2) + C);
        check("restart_frames", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            check("restart_silence", rx_q[0], 32'h0);
            check("restart_word", rx_q[1], 32'hC3A5_0F0F);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
